// File: rtl/biquad_coeff_sequencer.sv
// Coefficient bank for NCH biquad channels with a WISHBONE front end.
// Coefficients are staged over the bus and read back through a dedicated port.
// A commit streams every enabled channel's coefficients into the filter cores,
// one per cycle, and then pulses the per-channel coefficient update.
module biquad_coeff_sequencer #(
    parameter int unsigned NCH     = 4,
    parameter int unsigned NCOEFF  = 8,
    parameter int unsigned CBITS   = 18,
    parameter int unsigned ADRBITS = 9
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      wb_cyc_i,
    input  logic                      wb_stb_i,
    input  logic                      wb_we_i,
    input  logic [ADRBITS-1:0]        wb_adr_i,
    input  logic [31:0]               wb_dat_i,
    input  logic [3:0]                wb_sel_i,
    output logic                      wb_ack_o,
    output logic                      wb_err_o,
    output logic                      wb_rty_o,
    output logic [31:0]               wb_dat_o,
    input  logic                      global_update_i,
    output logic [CBITS-1:0]          coeff_dat_o,
    output logic [$clog2(NCOEFF)-1:0] coeff_adr_o,
    output logic [NCH-1:0]            coeff_wr_o,
    output logic [NCH-1:0]            coeff_update_o
);

    localparam int unsigned Depth  = NCH * NCOEFF;
    localparam int unsigned KW     = $clog2(NCOEFF);
    localparam int unsigned CHW    = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int unsigned IW     = $clog2(Depth);
    localparam int unsigned RamBase = 64;  // word index of byte address 0x100

    typedef enum logic [1:0] {StIdle, StPrime, StLoad, StUpdate} state_e;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [CBITS-1:0] stage_q [Depth];

    state_e           state_q;
    logic [CHW-1:0]   ch_q;
    logic [KW-1:0]    k_q;
    logic             pend_q;
    logic             commit_run_q;
    logic [7:0]       cnt_q;
    logic [NCH-1:0]   wr_q;
    logic [KW-1:0]    adr_q;
    logic [CBITS-1:0] dat_q;
    logic [NCH-1:0]   upd_q;

    logic             ack_q;
    logic [31:0]      rdat_q;
    logic [NCH-1:0]   mask_q;
    logic             cmd_commit_q;
    logic             cmd_upd_q;

    // ------------------------------------------------------------------
    // Bus decode
    // ------------------------------------------------------------------
    logic [31:0]      word;
    logic             is_ctrl;
    logic             is_status;
    logic             is_mask;
    logic             is_ram;
    logic [IW-1:0]    bus_idx;
    logic [CBITS-1:0] bus_ram_rd;
    logic             busy;
    logic             bus_req;
    logic             bus_stall;
    logic             bus_accept;
    logic             bus_wr;
    logic [31:0]      bus_rdata;
    logic             unused_bus;

    assign word      = 32'(wb_adr_i) >> 2;
    assign is_ctrl   = (word == 32'd0);
    assign is_status = (word == 32'd1);
    assign is_mask   = (word == 32'd2);
    assign is_ram    = (word >= 32'(RamBase)) && (word < 32'(RamBase + Depth));
    assign bus_idx   = IW'(word - 32'(RamBase));
    assign bus_ram_rd = stage_q[bus_idx];

    assign busy       = (state_q != StIdle);
    assign bus_req    = wb_cyc_i && wb_stb_i && !ack_q;
    // Only writes that could disturb an in-flight commit are held off.
    assign bus_stall  = busy && wb_we_i && (is_ram || is_ctrl || is_mask);
    assign bus_accept = bus_req && !bus_stall;
    assign bus_wr     = bus_accept && wb_we_i;

    assign unused_bus = ^{wb_sel_i[3:1], wb_dat_i};

    // Read mux; unmapped and write-only locations read as zero.
    always_comb begin
        bus_rdata = '0;
        if (is_status) begin
            bus_rdata = {16'h0, cnt_q, 7'h0, busy};
        end else if (is_mask) begin
            bus_rdata = {{(32 - NCH){1'b0}}, mask_q};
        end else if (is_ram) begin
            bus_rdata = {{(32 - CBITS){bus_ram_rd[CBITS-1]}}, bus_ram_rd};
        end
    end

    // Bus slave registers: ack, read data, channel mask, pending commands.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ack_q        <= 1'b0;
            rdat_q       <= '0;
            mask_q       <= '1;
            cmd_commit_q <= 1'b0;
            cmd_upd_q    <= 1'b0;
        end else begin
            ack_q        <= bus_accept;
            rdat_q       <= (bus_accept && !wb_we_i) ? bus_rdata : '0;
            cmd_commit_q <= bus_wr && is_ctrl && wb_sel_i[0] && wb_dat_i[0];
            cmd_upd_q    <= bus_wr && is_ctrl && wb_sel_i[0] && wb_dat_i[1] && !wb_dat_i[0];
            if (bus_wr && is_mask && wb_sel_i[0]) begin
                mask_q <= wb_dat_i[NCH-1:0];
            end
        end
    end

    // Staging RAM write port; contents deliberately survive reset.
    always_ff @(posedge clk_i) begin
        if (bus_wr && is_ram) begin
            stage_q[bus_idx] <= wb_dat_i[CBITS-1:0];
        end
    end

    // ------------------------------------------------------------------
    // Sequencer address generation
    // ------------------------------------------------------------------
    logic [CHW-1:0] first_ch;
    logic [CHW-1:0] next_ch;
    logic           has_next;
    logic           k_last;
    logic [CHW-1:0] seq_ch;
    logic [KW-1:0]  seq_k;
    logic [IW-1:0]  seq_idx;
    logic [NCH-1:0] glob_all;

    assign glob_all = {NCH{global_update_i}};

    // Pick the (channel, k) whose coefficient is presented in the next cycle.
    always_comb begin
        first_ch = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (mask_q[i]) first_ch = CHW'(i);
        end
        next_ch  = '0;
        has_next = 1'b0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (mask_q[i] && (i > int'(ch_q))) begin
                next_ch  = CHW'(i);
                has_next = 1'b1;
            end
        end
        k_last = (k_q == KW'(NCOEFF - 1));
        if (state_q == StPrime) begin
            seq_ch = first_ch;
            seq_k  = '0;
        end else if (k_last) begin
            seq_ch = next_ch;
            seq_k  = '0;
        end else begin
            seq_ch = ch_q;
            seq_k  = k_q + KW'(1);
        end
        seq_idx = IW'(int'(seq_ch) * int'(NCOEFF) + int'(seq_k));
    end

    // Commit FSM with registered core-side outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= StIdle;
            ch_q         <= '0;
            k_q          <= '0;
            pend_q       <= 1'b0;
            commit_run_q <= 1'b0;
            cnt_q        <= '0;
            wr_q         <= '0;
            adr_q        <= '0;
            dat_q        <= '0;
            upd_q        <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    wr_q   <= '0;
                    adr_q  <= '0;
                    dat_q  <= '0;
                    pend_q <= 1'b0;
                    upd_q  <= glob_all;
                    if (cmd_commit_q && (mask_q != '0)) begin
                        state_q      <= StPrime;
                        commit_run_q <= 1'b1;
                    end else if (cmd_upd_q && (mask_q != '0)) begin
                        state_q      <= StUpdate;
                        commit_run_q <= 1'b0;
                        upd_q        <= mask_q | glob_all;
                    end
                end
                StPrime: begin
                    pend_q  <= pend_q | global_update_i;
                    upd_q   <= '0;
                    ch_q    <= seq_ch;
                    k_q     <= seq_k;
                    wr_q    <= NCH'(1) << seq_ch;
                    adr_q   <= seq_k;
                    dat_q   <= stage_q[seq_idx];
                    state_q <= StLoad;
                end
                StLoad: begin
                    pend_q <= pend_q | global_update_i;
                    if (k_last && !has_next) begin
                        // A global request seen at any point of the load merges here.
                        state_q <= StUpdate;
                        wr_q    <= '0;
                        adr_q   <= '0;
                        dat_q   <= '0;
                        upd_q   <= mask_q | {NCH{pend_q | global_update_i}};
                    end else begin
                        ch_q  <= seq_ch;
                        k_q   <= seq_k;
                        wr_q  <= NCH'(1) << seq_ch;
                        adr_q <= seq_k;
                        dat_q <= stage_q[seq_idx];
                    end
                end
                StUpdate: begin
                    upd_q   <= '0;
                    pend_q  <= 1'b0;
                    wr_q    <= '0;
                    adr_q   <= '0;
                    dat_q   <= '0;
                    state_q <= StIdle;
                    if (commit_run_q) cnt_q <= cnt_q + 8'd1;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign wb_ack_o    = ack_q;
    assign wb_err_o    = 1'b0;
    assign wb_rty_o    = 1'b0;
    assign wb_dat_o    = rdat_q;
    assign coeff_dat_o = dat_q;
    assign coeff_adr_o = adr_q;
    assign coeff_wr_o  = wr_q;
    // A global request landing in the update cycle itself joins that pulse.
    assign coeff_update_o = upd_q | (glob_all & {NCH{state_q == StUpdate}});

endmodule
